// File: rtl/xbee_tx_pkg.sv
// Shared definitions for the XBee transmit sequencer: coder command codes,
// FSM state encoding and the elaboration-time helper functions.
package xbee_tx_pkg;

    localparam logic [2:0] ST_BUSY   = 3'b000;
    localparam logic [2:0] ST_ENCODE = 3'b001;
    localparam logic [2:0] ST_PUSH   = 3'b011;
    localparam logic [2:0] ST_MOVE   = 3'b100;
    localparam logic [2:0] ST_IDLE   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC1,
        S_ENC2,
        S_PUSH,
        S_MOVE,
        S_GAP
    } fsm_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int tick_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Command code the coder sees while the FSM sits in a given state.
    function automatic logic [2:0] state_code(input fsm_e s);
        case (s)
            S_ENC1, S_ENC2: return ST_ENCODE;
            S_PUSH:         return ST_PUSH;
            S_MOVE:         return ST_MOVE;
            S_GAP:          return ST_BUSY;
            default:        return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/xbee_tx_fifo.sv
// Byte FIFO with registered read; the read register doubles as the byte
// held steady for the coder until the next pop.
module xbee_tx_fifo
    import xbee_tx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [7:0]              wr_data_i,
    input  logic                    rd_en_i,
    output logic [7:0]              rd_data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   count_o
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    rd_data_q;
    logic          do_wr, do_rd;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = rd_data_q;

    // Full/empty come from the registered count, so a write arriving while
    // full is refused even when a pop happens in the same cycle.
    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem[rd_ptr_q];
            end
            count_q <= count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/xbee_tx_sequencer.sv
// Transmit sequencer: buffers application bytes and walks the frame coder
// through ENCODE/PUSH/MOVE one byte at a time, generating baud ticks.
module xbee_tx_sequencer
    import xbee_tx_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int BAUD          = 9600,
    parameter int FIFO_DEPTH    = 8,
    parameter int TIMEOUT_TICKS = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] WrData,
    input  logic       WrValid,
    output logic       WrReady,
    output logic [7:0] Din,
    output logic [2:0] State,
    output logic       TickTack,
    input  logic       Repeat,
    output logic       Busy,
    output logic       Err
);

    localparam int TICK_DIV = tick_div(CLK_HZ, BAUD);
    localparam int TW       = clog2(TICK_DIV);
    localparam int TOW      = clog2(TIMEOUT_TICKS + 1);

    fsm_e           state_q, state_d;
    logic [2:0]     state_code_q;
    logic           tick_q, tick_d;
    logic           err_q, err_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [TOW-1:0] tmo_q, tmo_d;
    logic           pop, wrap, first_move;

    logic                        fifo_full, fifo_empty;
    logic [clog2(FIFO_DEPTH):0]  fifo_count;

    xbee_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (Clk),
        .rst_ni    (Rst_n),
        .wr_en_i   (WrValid && WrReady),
        .wr_data_i (WrData),
        .rd_en_i   (pop),
        .rd_data_o (Din),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign WrReady  = !fifo_full;
    assign State    = state_code_q;
    assign TickTack = tick_q;
    assign Err      = err_q;
    assign Busy     = (state_q != S_IDLE) || (fifo_count != '0);

    // Both counters are zero only in the first MOVE cycle, where a stale
    // Repeat from the previous frame may still be visible.
    assign first_move = (tick_cnt_q == '0) && (tmo_q == '0);

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        tick_cnt_d = tick_cnt_q;
        tmo_d      = tmo_q;
        pop        = 1'b0;
        wrap       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_ENC1;
                end
            end
            S_ENC1: state_d = S_ENC2;
            S_ENC2: state_d = S_PUSH;
            S_PUSH: begin
                tick_cnt_d = '0;
                tmo_d      = '0;
                state_d    = S_MOVE;
            end
            S_MOVE: begin
                wrap       = (tick_cnt_q == TW'(TICK_DIV - 1));
                tick_cnt_d = wrap ? '0 : tick_cnt_q + TW'(1);
                if (wrap) tmo_d = tmo_q + TOW'(1);
                if (!first_move && Repeat) begin
                    state_d = S_GAP;
                end else if (tmo_q == TOW'(TIMEOUT_TICKS)) begin
                    err_d   = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        tick_d = wrap && (state_d == S_MOVE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_IDLE;
            state_code_q <= ST_IDLE;
            tick_q       <= 1'b0;
            err_q        <= 1'b0;
            tick_cnt_q   <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            state_code_q <= state_code(state_d);
            tick_q       <= tick_d;
            err_q        <= err_d;
            tick_cnt_q   <= tick_cnt_d;
            tmo_q        <= tmo_d;
        end
    end

endmodule

// File: tb/tb_xbee_tx_sequencer.sv
// Scoreboard bench: writes push expected frames, a coder model answers with
// Repeat, and a monitor checks each frame the sequencer drives.
module tb_xbee_tx_sequencer;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [7:0] WrData = 8'h00;
    logic       WrValid = 1'b0;
    logic       Repeat = 1'b0;
    logic       WrReady, TickTack, Busy, Err;
    logic [7:0] Din;
    logic [2:0] State;

    always #5 Clk = ~Clk;

    xbee_tx_sequencer #(
        .CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(8), .TIMEOUT_TICKS(16)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .WrData(WrData), .WrValid(WrValid),
        .WrReady(WrReady), .Din(Din), .State(State), .TickTack(TickTack),
        .Repeat(Repeat), .Busy(Busy), .Err(Err)
    );

    typedef struct {
        logic [7:0] data;
        int         move;
        int         ticks;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   lim_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    logic err_sticky = 1'b0;
    int   tt_idle_bad = 0;

    function automatic void check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endfunction

    // Coder model: Repeat stays high after a frame (stale) until the second
    // MOVE cycle, then rises again once the frame's tick limit is reached.
    int mc = 0, tk = 0, cur_lim = 0;
    always @(negedge Clk) begin
        if (!Rst_n) begin
            Repeat = 1'b0; mc = 0; tk = 0;
        end else if (State == 3'b100) begin
            if (mc == 0) cur_lim = (lim_q.size() != 0) ? lim_q.pop_front() : 0;
            mc++;
            if (mc == 2) Repeat = 1'b0;
            if (TickTack) begin
                tk++;
                if (cur_lim != 0 && tk == cur_lim) Repeat = 1'b1;
            end
        end else begin
            mc = 0; tk = 0;
        end
    end

    // Monitor: one frame = leaving IDLE with ENCODE until returning to IDLE.
    logic       in_frame = 1'b0, have_exp = 1'b0;
    logic [2:0] prev_state = 3'b111;
    logic [7:0] din0;
    int         n_enc, n_push, n_move, n_gap, n_ticks, first_off, last_rank, rank, bad;
    exp_t       cur;
    always @(negedge Clk) begin
        if (!Rst_n) begin
            in_frame = 1'b0; prev_state = 3'b111;
        end else begin
            if (!in_frame && prev_state == 3'b111 && State == 3'b001) begin
                in_frame = 1'b1; din0 = Din; last_rank = 0; bad = 0;
                n_enc = 0; n_push = 0; n_move = 0; n_gap = 0; n_ticks = 0; first_off = -1;
                if (exp_q.size() == 0) begin
                    have_exp = 1'b0; check("unexpected_frame", 1, 0);
                end else begin
                    have_exp = 1'b1; cur = exp_q.pop_front();
                    check("din_at_enc1", Din, cur.data);
                end
            end
            if (!in_frame && TickTack) tt_idle_bad++;
            if (in_frame) begin
                rank = 0;
                case (State)
                    3'b001: begin n_enc++; rank = 1; end
                    3'b011: begin n_push++; rank = 2; end
                    3'b100: begin
                        n_move++; rank = 3;
                        if (TickTack) begin
                            n_ticks++;
                            if (first_off < 0) first_off = n_move - 1;
                        end
                    end
                    3'b000: begin n_gap++; rank = 4; end
                    3'b111: rank = 5;
                    default: bad++;
                endcase
                if (rank < last_rank) bad++;
                last_rank = rank;
                if (State != 3'b100 && TickTack) bad++;
                if (Din != din0) bad++;
                if (State == 3'b111) begin
                    if (have_exp) begin
                        check("enc_cycles", n_enc, 2);
                        check("push_cycles", n_push, 1);
                        check("move_cycles", n_move, cur.move);
                        check("gap_cycles", n_gap, 1);
                        check("tick_count", n_ticks, cur.ticks);
                        check("first_tick_offset", first_off, 16);
                        check("err_flag", Err, cur.err);
                        check("frame_order_din_tick", bad, 0);
                    end
                    in_frame = 1'b0;
                end
            end
            prev_state = State;
        end
    end

    task automatic write_byte(input logic [7:0] d, input int lim, output int waited);
        exp_t e;
        waited = 0;
        @(negedge Clk);
        WrData = d; WrValid = 1'b1;
        while (!WrReady && waited < 2000) begin
            @(negedge Clk); waited++;
        end
        if (!WrReady) begin
            check("write_accept_timeout", 0, 1);
            WrValid = 1'b0;
        end else begin
            e.data = d;
            e.move = (lim != 0) ? 16 * lim + 1 : 257;
            e.ticks = (lim != 0) ? lim : 16;
            if (lim == 0) err_sticky = 1'b1;
            e.err = err_sticky;
            exp_q.push_back(e);
            lim_q.push_back(lim);
            @(posedge Clk);
            #1 WrValid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int quiet = 0, c = 0;
        while (quiet < 3 && c < 8000) begin
            @(negedge Clk); c++;
            quiet = Busy ? 0 : quiet + 1;
        end
        check("idle_reached", (quiet >= 3) ? 1 : 0, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int w;
        logic [7:0] burst [10];
        int c;

        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("reset_outputs", {State, WrReady, Busy, TickTack, Err}, 7'b1111000);
        end
        @(negedge Clk) Rst_n = 1'b1;

        // Single byte, coder answers after 13 ticks.
        write_byte(8'hA5, 13, w);
        wait_idle();

        // Ten writes back-to-back: nine fit (first pop frees a slot), tenth stalls.
        for (int i = 0; i < 10; i++) burst[i] = 8'(8'h30 + i * 7);
        for (int i = 0; i < 10; i++) begin
            write_byte(burst[i], 2, w);
            if (i == 8) check("wr9_not_held", w, 0);
            if (i == 9) check("wr10_held", (w > 0) ? 1 : 0, 1);
        end
        wait_idle();

        // Lost frame sets Err; following byte still goes out, Err stays set.
        write_byte(8'h3C, 0, w);
        write_byte(8'h5A, 3, w);
        wait_idle();
        check("err_sticky", Err, 1);

        // Reset in the middle of MOVE with another byte still queued.
        write_byte(8'h77, 13, w);
        write_byte(8'h11, 1, w);
        c = 0;
        while (State != 3'b100 && c < 200) begin
            @(negedge Clk); c++;
        end
        check("reached_move", State, 3'b100);
        repeat (20) @(negedge Clk);
        @(posedge Clk);
        #3 Rst_n = 1'b0;
        exp_q.delete(); lim_q.delete(); err_sticky = 1'b0;
        #1;
        check("async_reset_outputs", {State, WrReady, Busy, TickTack, Err}, 7'b1111000);
        check("async_reset_din", Din, 0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (6) @(negedge Clk);
        check("fifo_discarded", {State, Busy, Err}, 5'b11100);
        check("no_tick_outside_frames", tt_idle_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
